// File: rtl/hd_mux_pkg.sv
// Shared types, limits and helpers for the hd_mux_sw switchover multiplexer.
package hd_mux_pkg;

    localparam int unsigned N_MAX   = 16;
    localparam int unsigned W_MAX   = 64;
    localparam int unsigned GAP_MAX = 15;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic {
        ACTIVE,
        BLANK
    } state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/hd_mux_gap_cnt.sv
// Loadable down-counter that times the blanking gap; saturates at zero.
module hd_mux_gap_cnt
    import hd_mux_pkg::*;
(
    input  logic             ck,
    input  logic             rst,
    input  logic             ld,
    input  logic [CNT_W-1:0] ld_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge ck) begin
        if (rst) begin
            cnt <= '0;
        end else if (ld) begin
            cnt <= ld_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/hd_mux_sw.sv
// Registered N:1 multiplexer that blanks its output for GAP cycles whenever the
// selected channel changes, so consumers never see a sample straddling a source change.
module hd_mux_sw
    import hd_mux_pkg::*;
#(
    parameter int unsigned N   = 3,
    parameter int unsigned W   = 1,
    parameter int unsigned GAP = 2,
    localparam int unsigned SW = (clog2(N) < 1) ? 1 : clog2(N)
) (
    input  logic           CK,
    input  logic           RST,
    input  logic [N*W-1:0] A,
    input  logic [SW-1:0]  SL,
    input  logic           HOLD,
    output logic [W-1:0]   Z,
    output logic           ZV,
    output logic           BUSY,
    output logic           ERR
);

    // Extra bit keeps the range check meaningful when N is a power of two.
    localparam logic [SW:0]      N_EXT  = (SW + 1)'(N);
    localparam logic [CNT_W-1:0] GAP_LD = CNT_W'((GAP == 0) ? 0 : GAP - 1);

    state_t          state;
    logic [SW-1:0]   cur;
    logic [SW-1:0]   pend;
    logic            sl_bad;
    logic            sw_req;
    logic            restart;
    logic            cnt_ld;
    logic            cnt_dec;
    logic            cnt_zero;
    logic [SW-1:0]   idx;
    logic [W-1:0]    sel_data;

    hd_mux_gap_cnt u_gap_cnt (
        .ck     (CK),
        .rst    (RST),
        .ld     (cnt_ld),
        .ld_val (GAP_LD),
        .dec    (cnt_dec),
        .zero   (cnt_zero)
    );

    always_comb begin
        sl_bad  = ({1'b0, SL} >= N_EXT);
        sw_req  = !sl_bad && (SL != cur);
        restart = !sl_bad && (SL != pend);
        cnt_ld  = 1'b0;
        cnt_dec = 1'b0;
        idx     = cur;
        if (!HOLD) begin
            case (state)
                ACTIVE: begin
                    if (sw_req) begin
                        if (GAP == 0) begin
                            idx = SL;
                        end else begin
                            cnt_ld = 1'b1;
                        end
                    end
                end
                BLANK: begin
                    // A new legal target always restarts the full gap, even at completion.
                    if (restart) begin
                        cnt_ld = 1'b1;
                    end else if (!cnt_zero) begin
                        cnt_dec = 1'b1;
                    end else begin
                        idx = pend;
                    end
                end
                default: ;
            endcase
        end
        sel_data = A[32'(idx) * W +: W];
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            state <= ACTIVE;
            cur   <= '0;
            pend  <= '0;
            Z     <= '0;
            ZV    <= 1'b0;
            BUSY  <= 1'b0;
            ERR   <= 1'b0;
        end else if (HOLD) begin
            ERR <= 1'b0;
        end else begin
            ERR <= sl_bad;
            case (state)
                ACTIVE: begin
                    if (sw_req && (GAP != 0)) begin
                        pend  <= SL;
                        Z     <= '0;
                        ZV    <= 1'b0;
                        BUSY  <= 1'b1;
                        state <= BLANK;
                    end else begin
                        if (sw_req) begin
                            cur <= SL;
                        end
                        Z  <= sel_data;
                        ZV <= 1'b1;
                    end
                end
                BLANK: begin
                    if (restart) begin
                        pend <= SL;
                    end else if (cnt_zero) begin
                        cur   <= pend;
                        Z     <= sel_data;
                        ZV    <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= ACTIVE;
                    end
                end
                default: begin
                    state <= ACTIVE;
                end
            endcase
        end
    end

endmodule
